buck_cfg_regbank: RTL and testbench

//  Register bank and configuration controller behind spi_slave's wr_pulse/rd_req port.

---
 rtl/buck_reg_pkg.sv | 29 ++
 rtl/cfg_commit_fsm.sv | 65 ++++++
 rtl/buck_cfg_regbank.sv | 148 ++++++++++++++
 tb/tb_buck_cfg_regbank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buck_reg_pkg.sv
// Shared definitions for the buck converter configuration register bank.
// Contents:
//   REG_*            register addresses
//   ST_*             STATUS register bit positions
//   COMMIT_GO        COMMIT register bit that requests a shadow->active commit
//   commit_state_e   state encoding of the commit controller
package buck_reg_pkg;

    localparam int REG_CTRL     = 0;
    localparam int REG_DUTY     = 1;
    localparam int REG_PERIOD   = 2;
    localparam int REG_DEADTIME = 3;
    localparam int REG_STATUS   = 4;
    localparam int REG_COMMIT   = 5;

    localparam int ST_OCP       = 0;
    localparam int ST_OVP       = 1;
    localparam int ST_PENDING   = 2;
    localparam int ST_TIMEOUT   = 3;
    localparam int ST_DONE      = 4;

    localparam int COMMIT_GO    = 0;

    typedef enum logic {
        CS_IDLE    = 1'b0,
        CS_PENDING = 1'b1
    } commit_state_e;

endpackage

// File: rtl/cfg_commit_fsm.sv
// Commit controller: waits in PENDING for a PWM period boundary (or a disabled
// converter) before letting the register bank copy shadow to active.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   commit_go   1-cycle request to start a commit (ignored while pending)
//   pwm_sync    1-cycle pulse at the PWM period boundary
//   enable      current active converter enable (act_ctrl[0])
//   pending     high while a commit is waiting
//   apply       copy shadow->active on this edge
//   timeout     commit aborted on this edge
//
// state      | meaning
// CS_IDLE    | no commit outstanding
// CS_PENDING | commit requested, waiting for pwm_sync or enable=0
module cfg_commit_fsm
    import buck_reg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic commit_go,
    input  logic pwm_sync,
    input  logic enable,
    output logic pending,
    output logic apply,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    commit_state_e      state;
    logic [CNT_W-1:0]   wait_cnt;

    // Strobes act on the same edge the condition is seen, so they are decoded
    // from the registered state rather than registered themselves.
    assign pending = (state == CS_PENDING);
    assign apply   = pending && (pwm_sync || !enable);
    assign timeout = pending && !apply && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CS_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                CS_IDLE: begin
                    if (commit_go) begin
                        state    <= CS_PENDING;
                        wait_cnt <= '0;
                    end
                end
                CS_PENDING: begin
                    if (apply || timeout) begin
                        state <= CS_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= CS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/buck_cfg_regbank.sv
// Buck converter configuration register bank.
// Shadow CTRL/DUTY/PERIOD/DEADTIME registers are written over SPI and copied
// to the active set atomically on a PWM period boundary. STATUS holds sticky
// fault/commit flags (write-1-to-clear) plus a live commit_pending bit.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_pulse/addr/data register write port
//   rd_req/addr/data   register read port (rd_data is combinational)
//   pwm_sync           PWM period boundary pulse
//   fault_ocp/ovp      fault events; clear converter enable on the next edge
//   act_*              active configuration to the PWM core
//   cfg_update         1-cycle pulse coincident with newly applied active values
module buck_cfg_regbank
    import buck_reg_pkg::*;
#(
    parameter int ADDR_BITS   = 3,
    parameter int DATA_BITS   = 16,
    parameter int TIMEOUT_CYC = 65535,
    parameter int PERIOD_RST  = 500,
    parameter int DT_RST      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_pulse,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 pwm_sync,
    input  logic                 fault_ocp,
    input  logic                 fault_ovp,
    output logic [DATA_BITS-1:0] act_ctrl,
    output logic [DATA_BITS-1:0] act_duty,
    output logic [DATA_BITS-1:0] act_period,
    output logic [DATA_BITS-1:0] act_deadtime,
    output logic                 cfg_update
);

    logic [DATA_BITS-1:0] sh_ctrl, sh_duty, sh_period, sh_deadtime;
    logic [DATA_BITS-1:0] sh_ctrl_nxt, sh_duty_nxt, sh_period_nxt, sh_deadtime_nxt;
    logic                 st_ocp, st_ovp, st_timeout, st_done;
    logic [7:0]           commit_cnt;

    logic wr_ctrl, wr_duty, wr_period, wr_deadtime, wr_status, wr_commit;
    logic commit_go, pending, apply, timeout;

    // Read is combinational; the request strobe carries no information here.
    logic unused_rd_req;
    assign unused_rd_req = rd_req;

    assign wr_ctrl     = wr_pulse && (wr_addr == ADDR_BITS'(REG_CTRL));
    assign wr_duty     = wr_pulse && (wr_addr == ADDR_BITS'(REG_DUTY));
    assign wr_period   = wr_pulse && (wr_addr == ADDR_BITS'(REG_PERIOD));
    assign wr_deadtime = wr_pulse && (wr_addr == ADDR_BITS'(REG_DEADTIME));
    assign wr_status   = wr_pulse && (wr_addr == ADDR_BITS'(REG_STATUS));
    assign wr_commit   = wr_pulse && (wr_addr == ADDR_BITS'(REG_COMMIT));
    assign commit_go   = wr_commit && wr_data[COMMIT_GO];

    // Next shadow values double as the apply source, so a write landing on
    // the apply edge is carried into the active set.
    always_comb begin
        sh_ctrl_nxt     = wr_ctrl     ? wr_data : sh_ctrl;
        sh_duty_nxt     = wr_duty     ? wr_data : sh_duty;
        sh_period_nxt   = wr_period   ? wr_data : sh_period;
        sh_deadtime_nxt = wr_deadtime ? wr_data : sh_deadtime;
    end

    cfg_commit_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_commit_fsm (
        .clk       (clk),
        .rst       (rst),
        .commit_go (commit_go),
        .pwm_sync  (pwm_sync),
        .enable    (act_ctrl[0]),
        .pending   (pending),
        .apply     (apply),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ctrl      <= '0;
            sh_duty      <= '0;
            sh_period    <= DATA_BITS'(PERIOD_RST);
            sh_deadtime  <= DATA_BITS'(DT_RST);
            act_ctrl     <= '0;
            act_duty     <= '0;
            act_period   <= DATA_BITS'(PERIOD_RST);
            act_deadtime <= DATA_BITS'(DT_RST);
            cfg_update   <= 1'b0;
            commit_cnt   <= '0;
            st_ocp       <= 1'b0;
            st_ovp       <= 1'b0;
            st_timeout   <= 1'b0;
            st_done      <= 1'b0;
        end else begin
            sh_ctrl     <= sh_ctrl_nxt;
            sh_duty     <= sh_duty_nxt;
            sh_period   <= sh_period_nxt;
            sh_deadtime <= sh_deadtime_nxt;

            if (apply) begin
                act_ctrl     <= sh_ctrl_nxt;
                act_duty     <= sh_duty_nxt;
                act_period   <= sh_period_nxt;
                act_deadtime <= sh_deadtime_nxt;
                commit_cnt   <= commit_cnt + 8'd1;
            end
            // Fault shutdown takes priority over a coincident apply.
            if (fault_ocp || fault_ovp) begin
                act_ctrl[0] <= 1'b0;
            end
            cfg_update <= apply;

            // Sticky bits: a set event in the same cycle as a W1C wins.
            st_ocp     <= fault_ocp || (st_ocp     && !(wr_status && wr_data[ST_OCP]));
            st_ovp     <= fault_ovp || (st_ovp     && !(wr_status && wr_data[ST_OVP]));
            st_timeout <= timeout   || (st_timeout && !(wr_status && wr_data[ST_TIMEOUT]));
            st_done    <= apply     || (st_done    && !(wr_status && wr_data[ST_DONE]));
        end
    end

    logic [4:0] status_bits;
    always_comb begin
        status_bits             = '0;
        status_bits[ST_OCP]     = st_ocp;
        status_bits[ST_OVP]     = st_ovp;
        status_bits[ST_PENDING] = pending;
        status_bits[ST_TIMEOUT] = st_timeout;
        status_bits[ST_DONE]    = st_done;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_BITS'(REG_CTRL):     rd_data = sh_ctrl;
            ADDR_BITS'(REG_DUTY):     rd_data = sh_duty;
            ADDR_BITS'(REG_PERIOD):   rd_data = sh_period;
            ADDR_BITS'(REG_DEADTIME): rd_data = sh_deadtime;
            ADDR_BITS'(REG_STATUS):   rd_data = DATA_BITS'(status_bits);
            ADDR_BITS'(REG_COMMIT):   rd_data = DATA_BITS'(commit_cnt);
            default:                  rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_buck_cfg_regbank.sv
module tb_buck_cfg_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pulse;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        pwm_sync;
    logic        fault_ocp;
    logic        fault_ovp;

    logic [15:0] rd_data, act_ctrl, act_duty, act_period, act_deadtime;
    logic        cfg_update;
    logic [15:0] rd_data_to, act_ctrl_to, act_duty_to, act_period_to, act_deadtime_to;
    logic        cfg_update_to;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buck_cfg_regbank dut (
        .clk          (clk),
        .rst          (rst),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_sync     (pwm_sync),
        .fault_ocp    (fault_ocp),
        .fault_ovp    (fault_ovp),
        .act_ctrl     (act_ctrl),
        .act_duty     (act_duty),
        .act_period   (act_period),
        .act_deadtime (act_deadtime),
        .cfg_update   (cfg_update)
    );

    // Short-timeout instance sharing the same stimulus, used for the abort path.
    buck_cfg_regbank #(.TIMEOUT_CYC(16)) dut_to (
        .clk          (clk),
        .rst          (rst),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data_to),
        .pwm_sync     (pwm_sync),
        .fault_ocp    (fault_ocp),
        .fault_ovp    (fault_ovp),
        .act_ctrl     (act_ctrl_to),
        .act_duty     (act_duty_to),
        .act_period   (act_period_to),
        .act_deadtime (act_deadtime_to),
        .cfg_update   (cfg_update_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_pulse = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_pulse = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        rd_req  = 1'b1;
        @(negedge clk);
        chk(tag, rd_data, exp);
        rd_req  = 1'b0;
    endtask

    task automatic rd_chk_to(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        rd_req  = 1'b1;
        @(negedge clk);
        chk(tag, rd_data_to, exp);
        rd_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        wr_pulse  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        pwm_sync  = 1'b0;
        fault_ocp = 1'b0;
        fault_ovp = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset values
        do_reset();
        chk("rst_act_period", act_period, 16'd500);
        chk("rst_act_dt", act_deadtime, 16'd10);
        chk("rst_act_ctrl", act_ctrl, 16'h0000);
        chk("rst_act_duty", act_duty, 16'h0000);
        chk("rst_to_period", act_period_to, 16'd500);
        rd_chk("rst_status", 3'd4, 16'h0000);
        rd_chk("rst_commit_cnt", 3'd5, 16'h0000);
        rd_chk("rst_sh_period", 3'd2, 16'd500);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cfg_update", {31'd0, cfg_update}, 32'd0);
        end

        // 2: commit with converter disabled applies on the next edge
        do_write(3'd1, 16'h0123);
        do_write(3'd0, 16'h0001);
        do_write(3'd5, 16'h0001);
        chk("c2_duty_hold", act_duty, 16'h0000);
        chk("c2_no_upd_yet", {31'd0, cfg_update}, 32'd0);
        rd_chk("c2_pending", 3'd4, 16'h0004);
        tick();
        chk("c2_act_duty", act_duty, 16'h0123);
        chk("c2_act_ctrl", act_ctrl, 16'h0001);
        chk("c2_cfg_update", {31'd0, cfg_update}, 32'd1);
        tick();
        chk("c2_cfg_upd_1cyc", {31'd0, cfg_update}, 32'd0);
        rd_chk("c2_commit_cnt", 3'd5, 16'h0001);
        rd_chk("c2_status_done", 3'd4, 16'h0010);

        // 3: enabled converter waits for pwm_sync 20 cycles after COMMIT
        do_write(3'd4, 16'h0010);
        do_write(3'd2, 16'h0400);
        do_write(3'd5, 16'h0001);
        for (int i = 0; i < 19; i++) begin
            tick();
            if (i == 0 || i == 18) begin
                chk("c3_period_hold", act_period, 16'd500);
                rd_chk("c3_pending", 3'd4, 16'h0004);
            end
        end
        pwm_sync = 1'b1;
        tick();
        pwm_sync = 1'b0;
        chk("c3_act_period", act_period, 16'h0400);
        chk("c3_cfg_update", {31'd0, cfg_update}, 32'd1);
        chk("c3_act_ctrl", act_ctrl, 16'h0001);
        rd_chk("c3_commit_cnt", 3'd5, 16'h0002);

        // 4: commit timeout on the TIMEOUT_CYC=16 instance
        do_reset();
        do_write(3'd0, 16'h0001);
        do_write(3'd5, 16'h0001);
        tick();
        do_write(3'd4, 16'h0010);
        chk("c4_to_enabled", act_ctrl_to, 16'h0001);
        do_write(3'd2, 16'h0222);
        do_write(3'd5, 16'h0001);
        repeat (15) tick();
        rd_chk_to("c4_still_pending", 3'd4, 16'h0004);
        tick();
        rd_chk_to("c4_timeout", 3'd4, 16'h0008);
        chk("c4_period_kept", act_period_to, 16'd500);
        chk("c4_no_update", {31'd0, cfg_update_to}, 32'd0);
        rd_chk_to("c4_commit_cnt", 3'd5, 16'h0001);
        do_write(3'd4, 16'h0008);
        rd_chk_to("c4_w1c", 3'd4, 16'h0000);

        // 5: faults
        do_reset();
        do_write(3'd0, 16'h0001);
        do_write(3'd5, 16'h0001);
        tick();
        do_write(3'd4, 16'h0010);
        chk("c5_enabled", act_ctrl, 16'h0001);
        fault_ocp = 1'b1;
        tick();
        fault_ocp = 1'b0;
        chk("c5_fault_off", act_ctrl, 16'h0000);
        rd_chk("c5_status_ocp", 3'd4, 16'h0001);
        rd_chk("c5_shadow_kept", 3'd0, 16'h0001);
        fault_ocp = 1'b1;
        do_write(3'd4, 16'h0001);
        fault_ocp = 1'b0;
        rd_chk("c5_set_wins", 3'd4, 16'h0001);
        do_write(3'd4, 16'h0001);
        rd_chk("c5_w1c_ocp", 3'd4, 16'h0000);
        // fault on the apply edge overrides the enable being applied
        do_write(3'd5, 16'h0001);
        fault_ovp = 1'b1;
        tick();
        fault_ovp = 1'b0;
        chk("c5_fault_over_apply", act_ctrl, 16'h0000);
        chk("c5_apply_upd", {31'd0, cfg_update}, 32'd1);
        rd_chk("c5_status_ovp_done", 3'd4, 16'h0012);
        // write on the apply edge is carried into the active set
        do_write(3'd4, 16'h0012);
        do_write(3'd5, 16'h0001);
        do_write(3'd1, 16'h0055);
        chk("c5_write_first", act_duty, 16'h0055);
        chk("c5_wf_update", {31'd0, cfg_update}, 32'd1);
        do_write(3'd5, 16'h0002);
        rd_chk("c5_go_bit_clear", 3'd4, 16'h0010);
        rd_chk("c5_commit_cnt", 3'd5, 16'h0003);

        // 6: commit counter wrap and reserved addresses
        do_reset();
        for (int i = 0; i < 255; i++) begin
            do_write(3'd5, 16'h0001);
            tick();
        end
        rd_chk("c6_cnt_255", 3'd5, 16'h00FF);
        do_write(3'd5, 16'h0001);
        tick();
        rd_chk("c6_cnt_wrap", 3'd5, 16'h0000);
        do_write(3'd6, 16'hFFFF);
        rd_chk("c6_rsvd6", 3'd6, 16'h0000);
        rd_chk("c6_rsvd7", 3'd7, 16'h0000);
        rd_chk("c6_sh_ctrl", 3'd0, 16'h0000);
        rd_chk("c6_sh_duty", 3'd1, 16'h0000);
        rd_chk("c6_sh_period", 3'd2, 16'd500);
        rd_chk("c6_sh_dt", 3'd3, 16'd10);
        rd_chk("c6_status", 3'd4, 16'h0010);
        rd_chk("c6_cnt_kept", 3'd5, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
